// File: rtl/io_pkg.sv
// Register map and status-bit layout shared by the I/O peripheral block and its FIFO.
package io_pkg;

  localparam logic [2:0] REG_KDATA = 3'd0;
  localparam logic [2:0] REG_TIMER = 3'd1;
  localparam logic [2:0] REG_KSTAT = 3'd2;
  localparam logic [2:0] REG_TCMP  = 3'd3;
  localparam logic [2:0] REG_TSTAT = 3'd4;
  localparam int unsigned NUM_REGS = 5;

  // KSTAT = {count[5:0], ovf, nonempty}
  localparam int KSTAT_NONEMPTY = 0;
  localparam int KSTAT_OVF      = 1;
  localparam int KSTAT_CNT_LSB  = 2;

  // TSTAT read/write bit positions
  localparam int TSTAT_FLAG = 0;
  localparam int TSTAT_CLR  = 0;
  localparam int TSTAT_EN   = 1;

endpackage

// File: rtl/io_fifo.sv
// Circular keyboard buffer with a sticky overflow flag; a pop and a push may happen in one cycle.
module io_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr_ovf,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO can still accept the byte.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !do_push) ovf <= 1'b1;
      else if (clr_ovf)     ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/io_ports.sv
// Memory-mapped I/O block: keyboard FIFO, tick timer with compare interrupt, border colour.
// r/w are one-cycle strobes with no backpressure: every access completes in its own cycle.
module io_ports
  import io_pkg::*;
#(
  parameter logic [15:0] BASE       = 16'h0020,
  parameter int          FIFO_DEPTH = 8,
  parameter int          CLK_HZ     = 25000000,
  parameter int          TICK_HZ    = 100,
  parameter int          BORDER_W   = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [15:0]         a,
  input  logic [7:0]          o,
  input  logic                r,
  input  logic                w,
  input  logic                p_kdone,
  input  logic [7:0]          p_ascii,
  output logic [BORDER_W-1:0] p_border,
  output logic                irq,
  output logic [7:0]          p
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  logic [15:0]   off;
  logic          in_win;
  logic          hit_kdata, hit_timer, hit_kstat, hit_tcmp, hit_tstat;
  logic [7:0]    kb_head;
  logic [CW-1:0] kb_count;
  logic          kb_full, kb_empty, kb_ovf;
  logic [5:0]    cnt6;
  logic [PW-1:0] presc;
  logic [7:0]    tcount;
  logic [7:0]    tnext;
  logic [7:0]    tcmp;
  logic          tick;
  logic          match;
  logic          irq_flag;
  logic          irq_en;

  assign off       = a - BASE;
  assign in_win    = (a >= BASE) && (off < 16'(NUM_REGS));
  assign hit_kdata = in_win && (off[2:0] == REG_KDATA);
  assign hit_timer = in_win && (off[2:0] == REG_TIMER);
  assign hit_kstat = in_win && (off[2:0] == REG_KSTAT);
  assign hit_tcmp  = in_win && (off[2:0] == REG_TCMP);
  assign hit_tstat = in_win && (off[2:0] == REG_TSTAT);

  io_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_kbd (
    .clock   (clock),
    .reset   (reset),
    .push    (p_kdone),
    .pop     (r & hit_kdata),
    .clr_ovf (r & hit_kstat),
    .din     (p_ascii),
    .head    (kb_head),
    .count   (kb_count),
    .full    (kb_full),
    .empty   (kb_empty),
    .ovf     (kb_ovf)
  );

  assign cnt6 = 6'(kb_count);

  always_comb begin
    p = 8'h00;
    if (hit_kdata) p = kb_head;
    if (hit_timer) p = tcount;
    if (hit_kstat) begin
      p[KSTAT_NONEMPTY]           = ~kb_empty;
      p[KSTAT_OVF]                = kb_ovf;
      p[KSTAT_CNT_LSB +: 6]       = cnt6;
    end
    if (hit_tcmp)  p = tcmp;
    if (hit_tstat) p[TSTAT_FLAG] = irq_flag;
  end

  assign tick  = (presc == PW'(DIV - 1));
  assign tnext = tcount + 8'd1;
  // A TIMER write on a tick cycle overrides the increment, so it also suppresses the compare.
  assign match = tick && !(w && hit_timer) && (tnext == tcmp);

  always_ff @(posedge clock) begin
    if (reset) begin
      presc    <= '0;
      tcount   <= 8'h00;
      tcmp     <= 8'h00;
      irq_flag <= 1'b0;
      irq_en   <= 1'b0;
      irq      <= 1'b0;
      p_border <= '0;
    end else begin
      if (w && hit_timer) begin
        tcount <= o;
        presc  <= '0;
      end else if (tick) begin
        tcount <= tnext;
        presc  <= '0;
      end else begin
        presc  <= presc + 1'b1;
      end
      if (w && hit_tcmp) tcmp <= o;
      if (match)                           irq_flag <= 1'b1;
      else if (w && hit_tstat && o[TSTAT_CLR]) irq_flag <= 1'b0;
      if (w && hit_tstat && o[TSTAT_EN]) irq_en <= 1'b1;
      irq <= irq_flag & irq_en;
      if (w && hit_kdata) p_border <= o[BORDER_W-1:0];
    end
  end

  logic unused_ok;
  assign unused_ok = kb_full;

endmodule

// File: tb/tb_io_ports.sv
// Randomized and directed bench for io_ports against a queue-based reference model.
module tb_io_ports;

  localparam logic [15:0] BASE  = 16'h0020;
  localparam int          DEPTH = 8;
  localparam int          DIV   = 10;

  logic        clock;
  logic        reset;
  logic [15:0] a;
  logic [7:0]  o;
  logic        r;
  logic        w;
  logic        p_kdone;
  logic [7:0]  p_ascii;
  logic [2:0]  p_border;
  logic        irq;
  logic [7:0]  p;

  int total = 0;
  int bad   = 0;

  io_ports #(
    .BASE(BASE), .FIFO_DEPTH(DEPTH), .CLK_HZ(1000), .TICK_HZ(100), .BORDER_W(3)
  ) dut (
    .clock(clock), .reset(reset), .a(a), .o(o), .r(r), .w(w),
    .p_kdone(p_kdone), .p_ascii(p_ascii), .p_border(p_border), .irq(irq), .p(p)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // reference model state
  logic [7:0] m_q[$];
  bit         m_ovf;
  int         m_tcount, m_presc, m_tcmp, m_border;
  bit         m_flag, m_en, m_irq;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [15:0] addr);
    int off;
    int sz;
    off = int'(addr) - int'(BASE);
    sz  = m_q.size();
    case (off)
      0: return (sz > 0) ? m_q[0] : 8'h00;
      1: return 8'(m_tcount);
      2: return 8'(((sz % 64) * 4) + (m_ovf ? 2 : 0) + ((sz != 0) ? 1 : 0));
      3: return 8'(m_tcmp);
      4: return {7'b0, m_flag};
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_step(input bit rs, input logic [15:0] addr, input logic [7:0] d,
                            input bit rd, input bit wr, input bit kd, input logic [7:0] asc);
    int  off;
    bit  match;
    bit  irq_next;
    if (rs) begin
      m_q.delete();
      m_ovf = 0; m_tcount = 0; m_presc = 0; m_tcmp = 0;
      m_flag = 0; m_en = 0; m_irq = 0; m_border = 0;
      return;
    end
    off      = int'(addr) - int'(BASE);
    irq_next = m_flag && m_en;
    if (rd && off == 0 && m_q.size() > 0) void'(m_q.pop_front());
    if (rd && off == 2) m_ovf = 0;
    if (kd) begin
      if (m_q.size() < DEPTH) m_q.push_back(asc);
      else m_ovf = 1;
    end
    match = 0;
    if (wr && off == 1) begin
      m_tcount = d;
      m_presc  = 0;
    end else if (m_presc == DIV - 1) begin
      m_presc  = 0;
      m_tcount = (m_tcount + 1) % 256;
      match    = (m_tcount == m_tcmp);
    end else begin
      m_presc++;
    end
    if (wr && off == 4) begin
      if (d[0] && !match) m_flag = 0;
      if (d[1]) m_en = 1;
    end
    if (match) m_flag = 1;
    if (wr && off == 3) m_tcmp = d;
    if (wr && off == 0) m_border = d % 8;
    m_irq = irq_next;
  endtask

  // driver: one bus cycle, checks p before the edge and registered outputs after it
  task automatic do_cycle(input bit rs, input logic [15:0] addr, input logic [7:0] d,
                          input bit rd, input bit wr, input bit kd, input logic [7:0] asc,
                          output logic [7:0] p_obs);
    @(negedge clock);
    reset = rs; a = addr; o = d; r = rd; w = wr; p_kdone = kd; p_ascii = asc;
    #1;
    p_obs = p;
    check("p", p, model_read(addr));
    @(posedge clock);
    model_step(rs, addr, d, rd, wr, kd, asc);
    #1;
    check("irq", {7'b0, irq}, {7'b0, m_irq});
    check("border", {5'b0, p_border}, 8'(m_border));
  endtask

  task automatic do_reset();
    logic [7:0] x;
    do_cycle(1, 16'h0000, 8'h00, 0, 0, 0, 8'h00, x);
  endtask

  task automatic idle(input int n);
    logic [7:0] x;
    for (int i = 0; i < n; i++) do_cycle(0, 16'h0000, 8'h00, 0, 0, 0, 8'h00, x);
  endtask

  task automatic wr_reg(input logic [2:0] off, input logic [7:0] d);
    logic [7:0] x;
    do_cycle(0, BASE + 16'(off), d, 0, 1, 0, 8'h00, x);
  endtask

  task automatic rd_reg(input logic [2:0] off, output logic [7:0] v);
    do_cycle(0, BASE + 16'(off), 8'h00, 1, 0, 0, 8'h00, v);
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic [7:0] x;
    do_cycle(0, 16'h0000, 8'h00, 0, 0, 1, b, x);
  endtask

  initial begin
    logic [7:0] v;
    logic [15:0] ra;
    logic [7:0]  rd_d;
    int op;
    reset = 1; a = 0; o = 0; r = 0; w = 0; p_kdone = 0; p_ascii = 0;
    do_reset();
    do_reset();

    // reset state: all registers read zero
    for (int i = 0; i < 5; i++) begin
      rd_reg(3'(i), v);
      check("reset_reg", v, 8'h00);
    end
    check("reset_irq", {7'b0, irq}, 8'h00);
    check("reset_border", {5'b0, p_border}, 8'h00);

    // basic FIFO ordering
    push_byte(8'h41); push_byte(8'h42); push_byte(8'h43);
    rd_reg(3'd2, v); check("kstat3", v, 8'h0D);
    rd_reg(3'd0, v); check("kd41", v, 8'h41);
    rd_reg(3'd0, v); check("kd42", v, 8'h42);
    rd_reg(3'd0, v); check("kd43", v, 8'h43);
    rd_reg(3'd2, v); check("kstat_empty", v, 8'h00);
    rd_reg(3'd0, v); check("kd_empty", v, 8'h00);

    // overflow
    for (int i = 1; i <= 9; i++) push_byte(8'(i));
    rd_reg(3'd2, v); check("kstat_ovf", v, 8'h23);
    for (int i = 1; i <= 8; i++) begin
      rd_reg(3'd0, v); check("drain", v, 8'(i));
    end
    rd_reg(3'd2, v); check("kstat_ovf_clr", v, 8'h00);

    // full FIFO, simultaneous push and pop
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    do_cycle(0, BASE, 8'h00, 1, 0, 1, 8'h99, v);
    check("full_pushpop_head", v, 8'h01);
    rd_reg(3'd2, v); check("full_pushpop_kstat", v, 8'h21);
    for (int i = 2; i <= 8; i++) begin
      rd_reg(3'd0, v); check("drain2", v, 8'(i));
    end
    rd_reg(3'd0, v); check("drain2_last", v, 8'h99);

    // empty FIFO, simultaneous push and pop
    do_cycle(0, BASE, 8'h00, 1, 0, 1, 8'h5A, v);
    check("empty_pushpop_p", v, 8'h00);
    rd_reg(3'd2, v); check("empty_pushpop_kstat", v, 8'h05);
    rd_reg(3'd0, v); check("empty_pushpop_data", v, 8'h5A);

    // border
    wr_reg(3'd0, 8'hFD);
    check("border_wr", {5'b0, p_border}, 8'h05);

    // timer compare and interrupt
    do_reset();
    wr_reg(3'd3, 8'h03);
    wr_reg(3'd4, 8'h02);
    wr_reg(3'd1, 8'h00);
    idle(30);
    check("irq_not_yet", {7'b0, irq}, 8'h00);
    rd_reg(3'd1, v); check("timer3", v, 8'h03);
    check("irq_set", {7'b0, irq}, 8'h01);
    rd_reg(3'd4, v); check("tstat_flag", v, 8'h01);
    wr_reg(3'd4, 8'h01);
    idle(1);
    check("irq_clr", {7'b0, irq}, 8'h00);

    // wrap, then a TIMER write landing on a tick
    wr_reg(3'd3, 8'h55);
    wr_reg(3'd1, 8'hFE);
    idle(20);
    rd_reg(3'd1, v); check("timer_wrap", v, 8'h00);
    wr_reg(3'd1, 8'h10);
    idle(9);
    wr_reg(3'd1, 8'h55);
    rd_reg(3'd1, v); check("timer_load_on_tick", v, 8'h55);
    rd_reg(3'd4, v); check("no_match_on_load", v, 8'h00);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ra   = 16'($urandom_range(16'h001E, 16'h0026));
      op   = $urandom_range(0, 3);
      rd_d = 8'($urandom_range(0, 255));
      if (op == 2 && ra == BASE + 16'd3 && $urandom_range(0, 1) == 1)
        rd_d = 8'((m_tcount + 1 + $urandom_range(0, 2)) % 256);
      do_cycle($urandom_range(0, 299) == 0, ra, rd_d, op == 1, op == 2,
               $urandom_range(0, 9) < 4, 8'($urandom_range(0, 255)), v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
